// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: captures one byte per din_rdy rising edge, FWFT read.
// Write visible on dout one cycle after capture; writes into a full FIFO without a pop are dropped (sticky overflow).
// Optional almost_full output is enabled by defining UART_RX_FIFO_ALMOST_FULL_EN.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     din,
  input  logic                  din_rdy,
  input  logic                  rd_en,
  input  logic                  clr_ovf,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  overflow,
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  output logic                  almost_full,
`endif
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  din_rdy_q;
  logic                  wr_stb;
  logic                  pop;
  logic                  wr_ok;
  logic                  drop;

  assign wr_stb = din_rdy & ~din_rdy_q;
  assign pop    = rd_en & dout_valid;
  // A pop in the same cycle frees the slot the write lands in, so full alone does not block it.
  assign wr_ok  = wr_stb & (~full | pop);
  assign drop   = wr_stb & full & ~pop;

  // Reset value 1 suppresses a spurious strobe from a level already high at release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) din_rdy_q <= 1'b1;
    else     din_rdy_q <= din_rdy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({wr_ok, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  assign dout_valid = (count != '0);
  assign full       = (count == DEPTH_C);
  assign dout       = dout_valid ? mem[rd_ptr] : '0;

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  assign almost_full = (count >= CW'(DEPTH - 2));
`endif

endmodule
